// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, word type and arbiter FSM states.
// Imported by the memory arbiter and its bench.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data side wins, fetch is protected by a starvation
// counter, and a busy-cycle timeout recovers from a hung RAM.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t state, next_state;
  ramstate_t  rs;

  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  word_t         addr_q;
  word_t         data_q;
  mem_op_t       op_q;

  logic dreq;
  logic force_i;
  logic grant_d;
  logic grant_i;
  logic done;
  logic ok;

  assign rs       = ramstate_t'(ramstate);
  assign ramaddr  = addr_q;
  assign ramstore = data_q;

  always_comb begin
    dreq    = dREN | dWEN;
    force_i = iREN && (starve_cnt == STARVE_MAX);
    grant_d = (state == IDLE) && dreq && !force_i;
    grant_i = (state == IDLE) && !grant_d && iREN;
    ok      = (rs == ACCESS);
    done    = (state != IDLE) &&
              (ok || rs == ERROR || tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    memerr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_d)      next_state = DBUSY;
        else if (grant_i) next_state = IBUSY;
      end
      IBUSY: begin
        ramREN = 1'b1;
        if (done) begin
          next_state = IDLE;
          iwait      = 1'b0;
          iload      = ok ? ramload : '0;
          memerr     = !ok;
        end
      end
      DBUSY: begin
        ramREN = (op_q == OP_READ);
        ramWEN = (op_q == OP_WRITE);
        if (done) begin
          next_state = IDLE;
          dwait      = 1'b0;
          dload      = (ok && op_q == OP_READ) ? ramload : '0;
          memerr     = !ok;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured only at grant, so the RAM never sees
  // requester changes mid-transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= OP_READ;
      starve_cnt <= '0;
    end else if (grant_d) begin
      addr_q <= daddr;
      data_q <= dstore;
      op_q   <= dWEN ? OP_WRITE : OP_READ;
      if (!iREN)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
    end else if (grant_i) begin
      addr_q     <= iaddr;
      op_q       <= OP_READ;
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      tmo_cnt <= '0;
    else if (state == IDLE || done)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, requester tasks and an ordered
// completion scoreboard.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic  side;
    word_t load;
    logic  err;
    word_t addr;
    logic  wen;
    word_t store;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        memerr;

  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  sb[$];
  exp_t  got_e;
  word_t mem [word_t];
  int    ram_mode;
  int    ram_lat;
  int    busy_cyc = 0;
  int    c1, c2, n_d, k_d;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t rd(word_t a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  function automatic exp_t mk(logic side, word_t load, logic err,
                              word_t addr, logic wen, word_t store);
    exp_t e;
    e.side = side; e.load = load; e.err = err;
    e.addr = addr; e.wen = wen; e.store = store;
    return e;
  endfunction

  // mode 0: ACCESS after ram_lat cycles, 1: ERROR, 2: hang in BUSY
  always @(posedge CLK) begin
    #1;
    if (ramREN || ramWEN) begin
      busy_cyc++;
      if (ram_mode == 2 || busy_cyc < ram_lat) begin
        ramstate = 2'd1; ramload = '0;
      end else if (ram_mode == 1) begin
        ramstate = 2'd3; ramload = '0;
      end else begin
        ramstate = 2'd2;
        ramload  = ramREN ? rd(ramaddr) : '0;
        if (ramWEN) mem[ramaddr] = ramstore;
      end
    end else begin
      busy_cyc = 0; ramstate = 2'd0; ramload = '0;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (!iwait || !dwait) begin
        check("wait_excl", 32'(iwait | dwait), 32'd1);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          check("side", 32'(iwait), 32'(got_e.side));
          check("load", iwait ? dload : iload, got_e.load);
          check("memerr", 32'(memerr), 32'(got_e.err));
          check("ramaddr", ramaddr, got_e.addr);
          check("ramWEN", 32'(ramWEN), 32'(got_e.wen));
          check("ramREN", 32'(ramREN), 32'(!got_e.wen));
          if (got_e.wen) check("ramstore", ramstore, got_e.store);
        end
      end else begin
        check("memerr_idle", 32'(memerr), 32'd0);
      end
    end
  end

  task automatic i_req(input word_t a, output int cyc);
    iREN = 1'b1; iaddr = a; cyc = 0;
    do begin
      @(posedge CLK); #2; cyc++;
    end while (iwait && cyc < 200);
    check("i_bound", 32'(iwait), 32'd0);
    iREN = 1'b0;
  endtask

  task automatic d_req(input logic wr, input word_t a, input word_t s,
                       output int cyc);
    dREN = !wr; dWEN = wr; daddr = a; dstore = s; cyc = 0;
    do begin
      @(posedge CLK); #2; cyc++;
    end while (dwait && cyc < 200);
    check("d_bound", 32'(dwait), 32'd0);
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_mode = 0; ram_lat = 1;
    mem[32'h40]  = 32'h8C010004;
    mem[32'h200] = 32'h0BADF00D;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_waits", 32'({iwait, dwait}), 32'd3);
    check("rst_loads", iload | dload, 32'd0);
    check("rst_memerr", 32'(memerr), 32'd0);
    RST = 1'b0;

    // lone i-read at minimum latency
    @(posedge CLK); #2;
    sb.push_back(mk(0, 32'h8C010004, 0, 32'h40, 0, 0));
    i_req(32'h40, c1);
    check("t2_lat", c1, 32'd1);

    // simultaneous i-read and d-write: data first, one idle gap
    @(posedge CLK); #2;
    sb.push_back(mk(1, 32'h0, 0, 32'h100, 1, 32'hDEADBEEF));
    sb.push_back(mk(0, rd(32'h44), 0, 32'h44, 0, 0));
    fork
      i_req(32'h44, c1);
      d_req(1'b1, 32'h100, 32'hDEADBEEF, c2);
    join
    check("t3_dlat", c2, 32'd1);
    check("t3_ilat", c1, 32'd3);
    @(posedge CLK); #2;
    sb.push_back(mk(1, 32'hDEADBEEF, 0, 32'h100, 0, 0));
    d_req(1'b0, 32'h100, 32'h0, c2);

    // starvation: 4 d-grants, forced i-grant, then d again
    @(posedge CLK); #2;
    for (int i = 0; i < 4; i++)
      sb.push_back(mk(1, 32'h0BADF00D, 0, 32'h200, 0, 0));
    sb.push_back(mk(0, rd(32'h80), 0, 32'h80, 0, 0));
    sb.push_back(mk(1, 32'h0BADF00D, 0, 32'h200, 0, 0));
    fork
      begin
        i_req(32'h80, c1);
        check("t4_starve", 32'(dut.starve_cnt), 32'd0);
      end
      begin
        dREN = 1'b1; daddr = 32'h200; n_d = 0; k_d = 0;
        while (n_d < 5 && k_d < 400) begin
          @(posedge CLK); #2; k_d++;
          if (!dwait) n_d++;
        end
        check("t4_dcount", n_d, 32'd5);
        dREN = 1'b0;
      end
    join
    check("t4_ilat", c1, 32'd9);

    // RAM error on a data read
    ram_mode = 1; ram_lat = 2;
    @(posedge CLK); #2;
    sb.push_back(mk(1, 32'h0, 1, 32'h180, 0, 0));
    d_req(1'b0, 32'h180, 32'h0, c2);
    check("t5_lat", c2, 32'd2);
    @(posedge CLK); #2;
    check("t5_idle", 32'({ramREN, ramWEN}), 32'd0);
    ram_mode = 0; ram_lat = 1;

    // hung RAM times out on the 64th busy cycle
    ram_mode = 2;
    @(posedge CLK); #2;
    sb.push_back(mk(0, 32'h0, 1, 32'h60, 0, 0));
    i_req(32'h60, c1);
    check("t6_lat", c1, 32'd64);
    ram_mode = 0;
    @(posedge CLK); #2;
    sb.push_back(mk(0, rd(32'h64), 0, 32'h64, 0, 0));
    i_req(32'h64, c1);
    check("t6_next", c1, 32'd1);

    // reset in the middle of a data write
    ram_mode = 2;
    @(posedge CLK); #2;
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h12345678;
    @(posedge CLK); #2;
    dWEN = 1'b0;
    check("t1_busy", 32'(ramWEN), 32'd1);
    RST = 1'b1;
    #1;
    check("t1_ramWEN", 32'(ramWEN), 32'd0);
    check("t1_dwait", 32'(dwait), 32'd1);
    check("t1_memerr", 32'(memerr), 32'd0);
    @(posedge CLK); #2;
    RST = 1'b0;
    ram_mode = 0;
    check("t1_state", 32'(dut.state), 32'(IDLE));
    check("t1_ramaddr", ramaddr, 32'd0);
    @(posedge CLK); #2;
    sb.push_back(mk(1, 32'h8C010004, 0, 32'h40, 0, 0));
    d_req(1'b0, 32'h40, 32'h0, c2);
    check("t1_recover", c2, 32'd1);

    repeat (3) @(posedge CLK);
    #2;
    check("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single-port RAM between the instruction fetch path (i-side, read-only) and the data memory path (d-side, read/write).
- Sits between the pipeline memory requesters and the RAM model.
- Produces the iwait/dwait signals that the hazard unit consumes to stall or advance pipeline registers.
- Data side has priority; a starvation counter guarantees forward progress for fetch; a timeout counter recovers from a hung RAM.

Parameters:
- STARVE_LIMIT, 4, consecutive d-grants allowed while iREN is pending before the i-side is forced to win.
- TIMEOUT_CYCLES, 64, busy-state cycles without ACCESS/ERROR before the transaction is aborted.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous reset, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  low for exactly the completion cycle of an i-transaction.
- iload  out  32  instruction word; valid when iwait low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write word.
- dwait  out  1  low for exactly the completion cycle of a d-transaction.
- dload  out  32  data read word; valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  one-cycle pulse on ERROR or timeout completion.

Behaviour:
- States: IDLE, IBUSY, DBUSY.
- Reset (asynchronous, any state, mid-transaction included): state=IDLE; starve_cnt=0; tmo_cnt=0; latched addr/data/op=0. Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, memerr=0.
- IDLE, sampled each edge:
  - If (dREN|dWEN) and not (iREN && starve_cnt==STARVE_LIMIT): go to DBUSY. Latch daddr and dstore. Latch op = write if dWEN, else read; dWEN wins when both dREN and dWEN are high.
  - If dREN|dWEN is high, iREN is high, and starve_cnt==STARVE_LIMIT: go to IBUSY.
  - Else if iREN: go to IBUSY and latch iaddr.
  - Else stay in IDLE.
  - In IDLE, ramREN=ramWEN=0 and both waits=1.
- starve_cnt:
  - On a d-grant with iREN high: increment, saturating at STARVE_LIMIT.
  - On a d-grant with iREN low, or on any i-grant: reset to 0.
- IBUSY/DBUSY:
  - ramaddr/ramstore/ramREN/ramWEN are driven from latched registers, so requester changes mid-transaction are ignored.
  - IBUSY always drives ramREN=1, ramWEN=0.
- Completion cycle: ramstate==ACCESS, ramstate==ERROR, or tmo_cnt==TIMEOUT_CYCLES-1.
  - The owning wait goes low combinationally in that cycle; the other wait stays 1.
  - On ACCESS: iload or dload = ramload (dload=0 for writes).
  - On ERROR or timeout: load=0 and memerr=1.
  - Next state is IDLE. tmo_cnt increments every busy cycle and clears on entering IDLE.
- Timing:
  - Minimum latency is 2 cycles from request to wait low: request seen in IDLE at edge N, RAM returns ACCESS in cycle N+1.
  - One bus turnaround cycle (IDLE) separates back-to-back transactions.
- Requester deasserts mid-transaction: the transaction still completes on the RAM, and the wait pulse is issued and ignored.
- The idle RAM never sees an enable; ramaddr holds its last latched value.

Decomposition:
- cpu_types_pkg provides ramstate_t (FREE/BUSY/ACCESS/ERROR) and word_t.
- Add arb_state_t (IDLE/IBUSY/DBUSY) to cpu_types_pkg.
- Counters and FSM stay in one module; no sub-module is warranted.

Test Plan:
1. Reset: assert RST mid-DBUSY -> same cycle ramWEN=0, dwait=1, memerr=0; after release, state is IDLE.
2. Lone i-read: iREN=1, iaddr=0x40, RAM returns ACCESS on the 2nd cycle with ramload=0x8C010004 -> ramaddr=0x40, ramREN=1; iwait low for exactly 1 cycle with iload=0x8C010004.
3. Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) -> d-side granted first with ramWEN=1, ramstore=0xDEADBEEF; i-side granted after one IDLE cycle.
4. Starvation: iREN held high with STARVE_LIMIT=4 while dREN is re-asserted continuously -> exactly 4 d-grants, then an i-grant, then starve_cnt=0.
5. RAM ERROR: ramstate=ERROR during DBUSY read -> dwait low and memerr=1 for 1 cycle, dload=0, back to IDLE.
6. Timeout: ramstate held BUSY with TIMEOUT_CYCLES=64 -> iwait low and memerr=1 on the 64th IBUSY cycle; next i-request is accepted normally.
